// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared spike-domain constants and saturating arithmetic
package spike_pkg;

   localparam int         DATA_W   = 8;
   localparam logic [7:0] DATA_MAX = 8'd255;

   function automatic logic [DATA_W-1:0] sat_add8(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0] w_sum;
      w_sum = {1'b0, a} + {1'b0, b};
      return w_sum[DATA_W] ? DATA_MAX : w_sum[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/leaky_trace.sv
// rtl/leaky_trace.sv - leaky synaptic trace: ceil-decay then saturating spike weight
module leaky_trace
   import spike_pkg::*;
#(
   parameter int WEIGHT      = 64,
   parameter int DECAY_SHIFT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spike,
   output logic [DATA_W-1:0] trace
);

   logic [DATA_W-1:0] r_trace;
   logic [DATA_W:0]   w_round;
   logic [DATA_W-1:0] w_dec;
   logic [DATA_W-1:0] w_add;

   // Rounding the decay up guarantees a spike-free trace always reaches zero.
   assign w_round = {1'b0, r_trace} + (DATA_W+1)'((1 << DECAY_SHIFT) - 1);
   assign w_dec   = DATA_W'(w_round >> DECAY_SHIFT);
   assign w_add   = spike ? DATA_W'(WEIGHT) : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_trace <= '0;
      end else begin
         r_trace <= sat_add8(r_trace - w_dec, w_add);
      end
   end

   assign trace = r_trace;

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate estimate plus leaky synaptic trace
module spike_rate_decoder
   import spike_pkg::*;
#(
   parameter int WINDOW      = 16,
   parameter int WEIGHT      = 64,
   parameter int DECAY_SHIFT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spike,
   input  logic              enable,
   output logic [DATA_W-1:0] rate,
   output logic              rate_valid,
   output logic [DATA_W-1:0] trace
);

   localparam int CNT_W = $clog2(WINDOW);

   logic [CNT_W-1:0]  r_win_cnt;
   logic [DATA_W-1:0] r_spk_cnt;
   logic [DATA_W-1:0] r_rate;
   logic              r_rate_valid;
   logic              w_terminal;
   logic [DATA_W-1:0] w_spk_next;

   assign w_terminal = (r_win_cnt == CNT_W'(WINDOW - 1));
   assign w_spk_next = sat_add8(r_spk_cnt, {{(DATA_W-1){1'b0}}, spike});

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_win_cnt    <= '0;
         r_spk_cnt    <= '0;
         r_rate       <= '0;
         r_rate_valid <= 1'b0;
      end else if (!enable) begin
         // Abort: partial window is dropped, last published rate is kept.
         r_win_cnt    <= '0;
         r_spk_cnt    <= '0;
         r_rate_valid <= 1'b0;
      end else if (w_terminal) begin
         r_rate       <= w_spk_next;
         r_rate_valid <= 1'b1;
         r_win_cnt    <= '0;
         r_spk_cnt    <= '0;
      end else begin
         r_win_cnt    <= r_win_cnt + 1'b1;
         r_spk_cnt    <= w_spk_next;
         r_rate_valid <= 1'b0;
      end
   end

   assign rate       = r_rate;
   assign rate_valid = r_rate_valid;

   leaky_trace #(
      .WEIGHT      (WEIGHT),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_trace (
      .clk     (clk),
      .reset_n (reset_n),
      .spike   (spike),
      .trace   (trace)
   );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - randomized and directed bench against a per-window rate/trace model
module tb_spike_rate_decoder;

   logic       clk;
   logic       reset_n;
   logic       spike;
   logic       enable;
   logic [7:0] rate       [3];
   logic       rate_valid [3];
   logic [7:0] trace      [3];

   int n_checks = 0;
   int n_fail   = 0;

   // Instance configurations: baseline, long window, heavy weight.
   int p_win [3] = '{16, 300, 16};
   int p_wgt [3] = '{64, 64, 200};
   int p_ds  [3] = '{1, 1, 1};

   int m_len   [3];
   int m_sum   [3];
   int m_rate  [3];
   int m_valid [3];
   int m_trace [3];

   spike_rate_decoder #(.WINDOW(16), .WEIGHT(64), .DECAY_SHIFT(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
      .rate(rate[0]), .rate_valid(rate_valid[0]), .trace(trace[0]));

   spike_rate_decoder #(.WINDOW(300), .WEIGHT(64), .DECAY_SHIFT(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
      .rate(rate[1]), .rate_valid(rate_valid[1]), .trace(trace[1]));

   spike_rate_decoder #(.WINDOW(16), .WEIGHT(200), .DECAY_SHIFT(1)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
      .rate(rate[2]), .rate_valid(rate_valid[2]), .trace(trace[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // The model keeps the spikes of the open window as a plain total and
   // publishes min(total,255) once WINDOW enabled edges have been seen.
   task automatic model_edge(input int i, input logic sp, input logic en, input logic rn);
      int d;
      int dec;
      int nxt;
      if (!rn) begin
         m_len[i] = 0; m_sum[i] = 0; m_rate[i] = 0; m_valid[i] = 0; m_trace[i] = 0;
         return;
      end
      d   = 2 ** p_ds[i];
      dec = (m_trace[i] + d - 1) / d;
      nxt = m_trace[i] - dec + (sp ? p_wgt[i] : 0);
      m_trace[i] = (nxt > 255) ? 255 : nxt;
      m_valid[i] = 0;
      if (!en) begin
         m_len[i] = 0; m_sum[i] = 0;
      end else begin
         m_len[i] += 1;
         m_sum[i] += sp;
         if (m_len[i] == p_win[i]) begin
            m_rate[i]  = (m_sum[i] > 255) ? 255 : m_sum[i];
            m_valid[i] = 1;
            m_len[i]   = 0;
            m_sum[i]   = 0;
         end
      end
   endtask

   task automatic tick(input logic sp, input logic en, input logic rn);
      spike = sp; enable = en; reset_n = rn;
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i, sp, en, rn);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rate%0d", i),  32'(rate[i]),       32'(m_rate[i]));
         check($sformatf("valid%0d", i), 32'(rate_valid[i]), 32'(m_valid[i]));
         check($sformatf("trace%0d", i), 32'(trace[i]),      32'(m_trace[i]));
      end
   endtask

   int tr_single [8] = '{64, 32, 16, 8, 4, 2, 1, 0};
   int tr_const  [8] = '{64, 96, 112, 120, 124, 126, 127, 127};
   int tr_heavy  [3] = '{200, 255, 255};

   initial begin
      int pulses;
      logic sp, en, rn;
      spike = 1'b0; enable = 1'b0; reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_len[i] = 0; m_sum[i] = 0; m_rate[i] = 0; m_valid[i] = 0; m_trace[i] = 0;
      end

      // Reset held with spike high
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b1, 1'b0);
         check("rst_rate", 32'(rate[0]), 0);
         check("rst_valid", 32'(rate_valid[0]), 0);
         check("rst_trace", 32'(trace[0]), 0);
      end

      // Single spike decay
      tick(1'b1, 1'b0, 1'b1);
      check("tr_single0", 32'(trace[0]), 32'(tr_single[0]));
      for (int k = 1; k < 8; k++) begin
         tick(1'b0, 1'b0, 1'b1);
         check($sformatf("tr_single%0d", k), 32'(trace[0]), 32'(tr_single[k]));
      end

      // Constant spike: trace settling, back-to-back windows, long-window saturation
      tick(1'b0, 1'b0, 1'b0);
      pulses = 0;
      for (int k = 0; k < 300; k++) begin
         tick(1'b1, 1'b1, 1'b1);
         if (k < 8) check($sformatf("tr_const%0d", k), 32'(trace[0]), 32'(tr_const[k]));
         if (k < 3) check($sformatf("tr_heavy%0d", k), 32'(trace[2]), 32'(tr_heavy[k]));
         if (k < 48 && rate_valid[0]) pulses++;
         if (k == 15 || k == 31 || k == 47) begin
            check("win16_valid", 32'(rate_valid[0]), 1);
            check("win16_rate", 32'(rate[0]), 16);
         end
         if (k == 299) begin
            check("win300_valid", 32'(rate_valid[1]), 1);
            check("win300_rate", 32'(rate[1]), 255);
         end
      end
      check("win16_pulses", 32'(pulses), 3);

      // Spike every 4th cycle
      tick(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 32; k++) begin
         tick(k % 4 == 3, 1'b1, 1'b1);
         if (k == 15 || k == 31) check("every4_rate", 32'(rate[0]), 4);
      end

      // Abort after 10 spikes, then re-enable with no spikes
      for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 1'b1);
         check("abort_valid", 32'(rate_valid[0]), 0);
      end
      for (int k = 0; k < 16; k++) begin
         tick(1'b0, 1'b1, 1'b1);
         if (k < 15) begin
            check("abort_hold_rate", 32'(rate[0]), 4);
            check("abort_hold_valid", 32'(rate_valid[0]), 0);
         end else begin
            check("abort_next_valid", 32'(rate_valid[0]), 1);
            check("abort_next_rate", 32'(rate[0]), 0);
         end
      end

      // Mid-window reset at win_cnt=9
      for (int k = 0; k < 9; k++) tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      check("midrst_trace", 32'(trace[0]), 0);
      for (int k = 0; k < 16; k++) begin
         tick(1'b0, 1'b1, 1'b1);
         check("midrst_valid", 32'(rate_valid[0]), (k == 15) ? 1 : 0);
      end

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         rn = ($urandom_range(0, 199) != 0);
         en = ($urandom_range(0, 9) != 0);
         sp = 1'($urandom_range(0, 1));
         tick(sp, en, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
